// File: rtl/bus_dpram_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_dpram_capture_ctrl_if
// Purpose : 16-bit register bus between a bus master and the capture
//           sequencer's 4-register window.
// Signals : Bus_CS       chip select
//           Bus_Wr_Rd_n  1 = write, 0 = read
//           Bus_Addr8    byte address
//           Bus_Wr_Data  write data
//           Bus_Rd_Data  read data (valid when Bus_Rd_DV)
//           Bus_Rd_DV    read data valid, one cycle after an accepted read
// ---------------------------------------------------------------------------
interface bus_dpram_capture_ctrl_if;
  logic        Bus_CS;
  logic        Bus_Wr_Rd_n;
  logic [15:0] Bus_Addr8;
  logic [15:0] Bus_Wr_Data;
  logic [15:0] Bus_Rd_Data;
  logic        Bus_Rd_DV;

  modport master (
    output Bus_CS, Bus_Wr_Rd_n, Bus_Addr8, Bus_Wr_Data,
    input  Bus_Rd_Data, Bus_Rd_DV
  );

  modport slave (
    input  Bus_CS, Bus_Wr_Rd_n, Bus_Addr8, Bus_Wr_Data,
    output Bus_Rd_Data, Bus_Rd_DV
  );
endinterface

// File: rtl/bus_dpram_capture_ctrl.sv
// ---------------------------------------------------------------------------
// bus_dpram_capture_ctrl
// Purpose : capture sequencer feeding the write port of a bus-readable
//           16-bit dual-port RAM. A bus master programs LEN, arms, aborts and
//           polls status; after arm + trigger, samples are streamed into RAM
//           addresses 0,1,2.. (ring wrap) until LEN samples are stored.
// Ports   : i_Bus_Clk     single clock (also the RAM write clock)
//           i_Bus_Rst     synchronous active-high reset
//           bus           register bus (slave side)
//           i_Smp_DV      sample valid
//           i_Smp_Data    sample data
//           i_Trig        capture trigger, level-sampled while ARMED
//           o_Wr_Addr     RAM write address
//           o_Wr_DV       RAM write strobe
//           o_Wr_Data     RAM write data
//           o_Busy        high while ARMED or CAPTURE
//           o_Done_Pulse  one-cycle pulse on entry to DONE
// Registers (byte offsets from BASE_ADDR8, bit0 of address ignored):
//           0x0 CTRL  W: bit0 ARM, bit1 ABORT (self-clearing), reads 0
//           0x2 STAT  R: [1:0] state, [2] wrapped
//           0x4 LEN   R/W: samples per run, 0 means DEPTH
//           0x6 COUNT R: samples written this run
// ---------------------------------------------------------------------------
module bus_dpram_capture_ctrl #(
  parameter int unsigned DEPTH      = 256,
  parameter logic [15:0] BASE_ADDR8 = 16'h0000
) (
  input  logic                       i_Bus_Clk,
  input  logic                       i_Bus_Rst,
  bus_dpram_capture_ctrl_if.slave    bus,
  input  logic                       i_Smp_DV,
  input  logic [15:0]                i_Smp_Data,
  input  logic                       i_Trig,
  output logic [$clog2(DEPTH)-1:0]   o_Wr_Addr,
  output logic                       o_Wr_DV,
  output logic [15:0]                o_Wr_Data,
  output logic                       o_Busy,
  output logic                       o_Done_Pulse
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Encoding is visible to software through STAT[1:0].
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e          state_q;
  logic [15:0]     len_q;
  logic [15:0]     count_q;
  logic            wrapped_q;
  logic [AW-1:0]   ptr_q;
  logic            busy_q;
  logic            done_pulse_q;
  logic            wr_dv_q;
  logic [AW-1:0]   wr_addr_q;
  logic [15:0]     wr_data_q;
  logic            rd_dv_q;
  logic [15:0]     rd_data_q;

  // ---------------- bus decode ----------------
  logic       hit, rd_acc, wr_acc;
  logic [1:0] reg_sel;
  logic       ctrl_wr, len_wr, arm_req, abort_req;
  logic       unused_addr_bit0;

  assign hit       = bus.Bus_CS && (bus.Bus_Addr8[15:3] == BASE_ADDR8[15:3]);
  assign rd_acc    = hit && !bus.Bus_Wr_Rd_n;
  assign wr_acc    = hit &&  bus.Bus_Wr_Rd_n;
  assign reg_sel   = bus.Bus_Addr8[2:1];
  assign unused_addr_bit0 = bus.Bus_Addr8[0];

  assign ctrl_wr   = wr_acc && (reg_sel == 2'd0);
  assign len_wr    = wr_acc && (reg_sel == 2'd2);
  // ABORT dominates ARM when both bits are written together.
  assign abort_req = ctrl_wr && bus.Bus_Wr_Data[1];
  assign arm_req   = ctrl_wr && bus.Bus_Wr_Data[0] && !bus.Bus_Wr_Data[1];

  logic [15:0] rd_mux;
  always_comb begin
    // NOTE: default assignment first so every path drives rd_mux; no latch is inferred.
    rd_mux = '0;
    case (reg_sel)
      2'd1:    rd_mux = {13'd0, wrapped_q, state_q};
      2'd2:    rd_mux = len_q;
      2'd3:    rd_mux = count_q;
      default: rd_mux = '0;
    endcase
  end

  // ---------------- sample acceptance ----------------
  logic          active, accept, last_acc, ptr_at_end;
  logic [16:0]   eff_len, count_inc;
  logic [AW-1:0] ptr_d;

  assign active     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  // The sample presented in the trigger cycle is part of the run; an abort
  // in the same cycle suppresses it.
  assign accept     = i_Smp_DV && !abort_req &&
                      ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && i_Trig));
  assign eff_len    = (len_q == 16'd0) ? 17'(DEPTH) : {1'b0, len_q};
  assign count_inc  = {1'b0, count_q} + 17'd1;
  assign last_acc   = accept && (count_inc == eff_len);
  assign ptr_at_end = (ptr_q == AW'(DEPTH - 1));
  assign ptr_d      = ptr_at_end ? '0 : ptr_q + AW'(1);

  // ---------------- state and datapath ----------------
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= ST_IDLE;
      len_q        <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      wr_dv_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_dv_q      <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      wr_dv_q      <= 1'b0;
      done_pulse_q <= 1'b0;
      rd_dv_q      <= rd_acc;
      if (rd_acc) rd_data_q <= rd_mux;

      // LEN is frozen while a run is in progress.
      if (len_wr && !active) len_q <= bus.Bus_Wr_Data;

      if (accept) begin
        wr_dv_q   <= 1'b1;
        wr_addr_q <= ptr_q;
        wr_data_q <= i_Smp_Data;
        ptr_q     <= ptr_d;
        count_q   <= count_q + 16'd1;
        if (ptr_at_end) wrapped_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          // No sample is accepted in these states, so clearing here cannot
          // collide with the datapath update above.
          if (arm_req) begin
            state_q   <= ST_ARMED;
            busy_q    <= 1'b1;
            ptr_q     <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (abort_req) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (i_Trig) begin
            if (last_acc) begin
              state_q      <= ST_DONE;
              busy_q       <= 1'b0;
              done_pulse_q <= 1'b1;
            end else begin
              state_q <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (abort_req) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (last_acc) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_Wr_Addr       = wr_addr_q;
  assign o_Wr_DV         = wr_dv_q;
  assign o_Wr_Data       = wr_data_q;
  assign o_Busy          = busy_q;
  assign o_Done_Pulse    = done_pulse_q;
  assign bus.Bus_Rd_Data = rd_data_q;
  assign bus.Bus_Rd_DV   = rd_dv_q;

endmodule

// File: tb/tb_bus_dpram_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_dpram_capture_ctrl
// Two instances (DEPTH 256 and DEPTH 8) share one stimulus stream. A
// behavioural model predicts bus read data and RAM writes into queues; a
// monitor on the falling edge pops and compares whenever an output is valid.
// ---------------------------------------------------------------------------
module tb_bus_dpram_capture_ctrl;

  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;

  typedef struct packed {
    logic        done;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic        rst = 1'b1;
  logic        cs = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        smp_dv = 1'b0, trig = 1'b0;
  logic [15:0] smp_data = '0;

  bus_dpram_capture_ctrl_if bus0 ();
  bus_dpram_capture_ctrl_if bus1 ();
  assign bus0.Bus_CS = cs;  assign bus0.Bus_Wr_Rd_n = wr;
  assign bus0.Bus_Addr8 = addr;  assign bus0.Bus_Wr_Data = wdata;
  assign bus1.Bus_CS = cs;  assign bus1.Bus_Wr_Rd_n = wr;
  assign bus1.Bus_Addr8 = addr;  assign bus1.Bus_Wr_Data = wdata;

  logic [7:0]  wa0;  logic [2:0] wa1;
  logic        wdv0, wdv1, busy0, busy1, done0, done1;
  logic [15:0] wd0, wd1;

  bus_dpram_capture_ctrl #(.DEPTH(256), .BASE_ADDR8(16'h0000)) dut0 (
    .i_Bus_Clk(clk), .i_Bus_Rst(rst), .bus(bus0),
    .i_Smp_DV(smp_dv), .i_Smp_Data(smp_data), .i_Trig(trig),
    .o_Wr_Addr(wa0), .o_Wr_DV(wdv0), .o_Wr_Data(wd0),
    .o_Busy(busy0), .o_Done_Pulse(done0));

  bus_dpram_capture_ctrl #(.DEPTH(8), .BASE_ADDR8(16'h0000)) dut1 (
    .i_Bus_Clk(clk), .i_Bus_Rst(rst), .bus(bus1),
    .i_Smp_DV(smp_dv), .i_Smp_Data(smp_data), .i_Trig(trig),
    .o_Wr_Addr(wa1), .o_Wr_DV(wdv1), .o_Wr_Data(wd1),
    .o_Busy(busy1), .o_Done_Pulse(done1));

  logic        wr_dv_w [2], rd_dv_w [2], busy_w [2], done_w [2];
  logic [15:0] wr_addr_w [2], wr_data_w [2], rd_data_w [2];
  assign wr_dv_w[0] = wdv0;            assign wr_dv_w[1] = wdv1;
  assign wr_addr_w[0] = {8'd0, wa0};   assign wr_addr_w[1] = {13'd0, wa1};
  assign wr_data_w[0] = wd0;           assign wr_data_w[1] = wd1;
  assign busy_w[0] = busy0;            assign busy_w[1] = busy1;
  assign done_w[0] = done0;            assign done_w[1] = done1;
  assign rd_dv_w[0] = bus0.Bus_Rd_DV;  assign rd_dv_w[1] = bus1.Bus_Rd_DV;
  assign rd_data_w[0] = bus0.Bus_Rd_Data;
  assign rd_data_w[1] = bus1.Bus_Rd_Data;

  // Scoreboard and reference model state
  wr_exp_t     wr_q [2][$];
  logic [15:0] rd_q [2][$];
  int          m_mode [2];
  int          m_len [2];
  int          m_cnt [2];
  bit          exp_busy [2];
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the reference model, evaluated on the inputs about to be
  // sampled at the next rising edge.
  task automatic step_model(input int k);
    int      d, rg, eff;
    bit      hit, active, ctrl_wr, arm, abort, accept, last;
    wr_exp_t e;
    d       = depth_of(k);
    hit     = cs && ((addr >> 3) == 16'd0);
    rg      = int'(addr[2:1]);
    active  = (m_mode[k] == M_ARMED) || (m_mode[k] == M_CAP);
    ctrl_wr = hit && wr && (rg == 0);
    abort   = ctrl_wr && wdata[1];
    arm     = ctrl_wr && wdata[0] && !wdata[1];
    eff     = (m_len[k] == 0) ? d : m_len[k];

    if (hit && !wr) begin
      case (rg)
        0:       rd_q[k].push_back(16'h0000);
        1:       rd_q[k].push_back(16'(m_mode[k] + ((m_cnt[k] >= d) ? 4 : 0)));
        2:       rd_q[k].push_back(16'(m_len[k]));
        default: rd_q[k].push_back(16'(m_cnt[k]));
      endcase
    end

    accept = smp_dv && !(abort && active) &&
             ((m_mode[k] == M_CAP) || ((m_mode[k] == M_ARMED) && trig));
    last   = accept && (m_cnt[k] + 1 == eff);
    if (accept) begin
      e.done = last;
      e.addr = 16'(m_cnt[k] % d);
      e.data = smp_data;
      wr_q[k].push_back(e);
      m_cnt[k]++;
    end

    if (!active && arm) begin
      m_mode[k] = M_ARMED;
      m_cnt[k]  = 0;
    end else if (active && abort)            m_mode[k] = M_IDLE;
    else if (last)                           m_mode[k] = M_DONE;
    else if (m_mode[k] == M_ARMED && trig)   m_mode[k] = M_CAP;

    if (hit && wr && rg == 2 && !active) m_len[k] = int'(wdata);
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = M_IDLE; m_len[k] = 0; m_cnt[k] = 0;
      end else begin
        step_model(k);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      exp_busy[k] = (m_mode[k] == M_ARMED) || (m_mode[k] == M_CAP);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    cycle();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a);
    cs = 1'b1; wr = 1'b0; addr = a;
    cycle();
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: pops expectations whenever a DUT output is valid.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_dv_w[k]) begin
          if (wr_q[k].size() == 0) begin
            check($sformatf("wr_unexpected[%0d]", k), 32'(wr_dv_w[k]), 32'd0);
          end else begin
            wr_exp_t e;
            e = wr_q[k].pop_front();
            check($sformatf("wr_addr[%0d]", k), 32'(wr_addr_w[k]), 32'(e.addr));
            check($sformatf("wr_data[%0d]", k), 32'(wr_data_w[k]), 32'(e.data));
            check($sformatf("done_pulse[%0d]", k), 32'(done_w[k]), 32'(e.done));
          end
        end else if (done_w[k]) begin
          check($sformatf("done_without_write[%0d]", k), 32'(done_w[k]), 32'd0);
        end

        if (rd_dv_w[k]) begin
          if (rd_q[k].size() == 0) begin
            check($sformatf("rd_unexpected[%0d]", k), 32'(rd_dv_w[k]), 32'd0);
          end else begin
            logic [15:0] r;
            r = rd_q[k].pop_front();
            check($sformatf("rd_data[%0d]", k), 32'(rd_data_w[k]), 32'(r));
          end
        end

        check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(exp_busy[k]));
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_len[k] = 0; m_cnt[k] = 0; exp_busy[k] = 1'b0;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Reset state through the register window
    bus_read(16'h0002); bus_read(16'h0004); bus_read(16'h0006); bus_read(16'h0000);
    idle(2);

    // LEN=4, samples before the trigger are ignored, then 6 back-to-back
    bus_write(16'h0004, 16'd4);
    bus_write(16'h0000, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      smp_dv = 1'b1; smp_data = 16'($urandom); cycle();
    end
    for (int i = 0; i < 6; i++) begin
      trig = (i == 0); smp_dv = 1'b1; smp_data = 16'($urandom); cycle();
    end
    trig = 1'b0; smp_dv = 1'b0;
    idle(2);
    bus_read(16'h0002); bus_read(16'h0006);

    // LEN=0 with gapped samples: full-depth run on each instance
    bus_write(16'h0004, 16'd0);
    bus_write(16'h0000, 16'h0001);
    trig = 1'b1; cycle(); trig = 1'b0;
    for (int i = 0; i < 2000 && m_mode[0] != M_DONE; i++) begin
      smp_dv = 1'($urandom); smp_data = 16'($urandom); cycle();
    end
    smp_dv = 1'b0;
    idle(2);
    bus_read(16'h0002); bus_read(16'h0006);

    // LEN=10: wraps on the 8-deep instance only
    bus_write(16'h0004, 16'd10);
    bus_write(16'h0000, 16'h0001);
    trig = 1'b1;
    for (int i = 0; i < 200 && (m_mode[0] != M_DONE || m_mode[1] != M_DONE); i++) begin
      smp_dv = 1'($urandom); smp_data = 16'($urandom); cycle();
      trig = 1'b0;
    end
    smp_dv = 1'b0; trig = 1'b0;
    idle(2);
    bus_read(16'h0002); bus_read(16'h0006); bus_read(16'h0005);

    // Abort mid-run; the sample in the abort cycle must be dropped
    bus_write(16'h0004, 16'd0);
    bus_write(16'h0000, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      trig = (i == 0); smp_dv = 1'b1; smp_data = 16'($urandom); cycle();
    end
    trig = 1'b0;
    smp_data = 16'($urandom);
    bus_write(16'h0000, 16'h0002);
    smp_dv = 1'b1; smp_data = 16'($urandom); cycle(); smp_dv = 1'b0;
    bus_read(16'h0002);
    bus_write(16'h0004, 16'd5);
    bus_read(16'h0004); bus_read(16'h0006);

    // ARM+ABORT together from IDLE; unmapped reads
    bus_write(16'h0000, 16'h0003);
    bus_read(16'h0002);
    bus_read(16'h0008); bus_read(16'h0010); bus_read(16'h8002);
    idle(2);

    // Random mixed traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r        = int'($urandom_range(0, 15));
      smp_dv   = 1'($urandom);
      smp_data = 16'($urandom);
      trig     = ($urandom_range(0, 3) == 0);
      if (r == 0) begin
        cs = 1'b1; wr = 1'b1; addr = 16'h0000;
        wdata = ($urandom_range(0, 7) == 0) ? 16'h0002 : 16'h0001;
      end else if (r == 1) begin
        cs = 1'b1; wr = 1'b1; addr = 16'h0004; wdata = 16'($urandom_range(0, 12));
      end else if (r == 2 || r == 3) begin
        cs = 1'b1; wr = 1'b0; addr = 16'($urandom_range(0, 7));
      end else if (r == 4) begin
        cs = 1'b1; wr = 1'($urandom); addr = 16'($urandom_range(8, 16'hFFFF));
        wdata = 16'($urandom);
      end
      cycle();
      cs = 1'b0; wr = 1'b0;
    end
    smp_dv = 1'b0; trig = 1'b0;

    // Reset in the middle of a capture
    bus_write(16'h0000, 16'h0002);
    bus_write(16'h0004, 16'd0);
    bus_write(16'h0000, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      trig = 1'b1; smp_dv = 1'b1; smp_data = 16'($urandom); cycle();
    end
    rst = 1'b1; idle(2);
    rst = 1'b0; trig = 1'b0; smp_dv = 1'b0;
    idle(1);
    bus_read(16'h0002); bus_read(16'h0004); bus_read(16'h0006);
    idle(4);

    for (int k = 0; k < 2; k++) begin
      check($sformatf("wr_pending[%0d]", k), 32'(wr_q[k].size()), 32'd0);
      check($sformatf("rd_pending[%0d]", k), 32'(rd_q[k].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
